layer_priority_compositor: RTL and testbench
============================================

// Module: layer_priority_compositor
// PURPOSE
//  N-layer pixel compositor for the VGA path: picks the highest-priority active layer per pixel, else background.
//  Adds per-frame layer enable mask (shadow-loaded at frame start), colour-key transparency and a 2-stage pipeline.
//  Sits between the object drawers/bitmaps and the VGA RGB output register.
// PARAMETERS
//  NUM_LAYERS  4      number of drawable layers; index 0 = highest priority
//  RGB_W       8      pixel colour width (RRRGGGBB at 8)
//  KEY_EN      1      1: layer pixels equal to KEY_RGB are treated as not requested
//  KEY_RGB     8'hFF  transparent colour key (RGB_W bits)
// PORTS
//  clk              in   1               system clock
//  reset            in   1               async, active-high reset
//  pix_valid        in   1               pixel inputs valid this cycle
//  frame_start      in   1               one-cycle strobe, first cycle of a frame
//  layer_req        in   NUM_LAYERS      per-layer draw request
//  layer_rgb        in   NUM_LAYERS*RGB_W  layer colours, layer k at [k*RGB_W +: RGB_W]
//  bg_rgb           in   RGB_W           background (MIF) colour
//  layer_en_next    in   NUM_LAYERS      enable mask to apply from next frame_start
//  rgb_out          out  RGB_W           composited pixel
//  rgb_valid        out  1               rgb_out valid
//  layer_sel        out  $clog2(NUM_LAYERS+1)  winning layer index; NUM_LAYERS = background
//  collision_flags  out  NUM_LAYERS-1    (COMPOSITOR_COLLISION_EN only) see CONFIGURATION
// BEHAVIOUR
//  Reset: rgb_out=0, rgb_valid=0, layer_sel=NUM_LAYERS, en_shadow=all 1s, collision_flags=0, sticky=0.
//  Mask: mask_now = frame_start ? layer_en_next : en_shadow; en_shadow<=layer_en_next on frame_start.
//   frame_start with pix_valid in same cycle: that pixel uses the NEW mask.
//  eff_req[k] = layer_req[k] & mask_now[k] & (!KEY_EN | layer_rgb[k]!=KEY_RGB).
//  Winner = lowest k with eff_req[k]; none -> background, index NUM_LAYERS.
//  Stage 1 (on pix_valid): register winner index + colour; s1_valid<=pix_valid every cycle.
//  Stage 2: rgb_out/layer_sel load when s1_valid; rgb_valid<=s1_valid.
//  Latency exactly 2 clk from pix_valid to rgb_valid; full throughput, no stall/backpressure.
//  pix_valid low: data regs hold, valid bits clear; rgb_out holds last pixel.
//  Reset mid-line: pipeline flushed, in-flight pixels discarded, mask returns to all 1s.
//  All-zero mask: every pixel = bg_rgb, layer_sel=NUM_LAYERS.
// CONFIGURATION
//  Macro COMPOSITOR_COLLISION_EN.
//  Defined: sticky[k-1] sets when pix_valid & eff_req[0] & eff_req[k] (k=1..N-1).
//   On frame_start: collision_flags<=sticky (previous frame); sticky<=hits of current pixel only.
//   Flags are stable for the whole following frame.
//  Undefined: collision_flags port and sticky logic absent; all other behaviour identical.
// STRUCTURE
//  Package compositor_pkg: LAYER_PLAYER=0 and other layer index constants, localparam SEL_W,
//   typedef logic [RGB_W-1:0] rgb_t, BG_SEL constant.
//  Sub-module layer_prio_enc: combinational lowest-index encoder (eff_req -> index, found).
// TESTING
//  1 Reset high mid-stream -> all outputs at reset values next edge; rgb_valid=0 for 2 clk after release+pix_valid.
//  2 N=4, req=4'b0110, rgb1=8'h1C, rgb2=8'hE0 -> 2 clk later rgb_out=8'h1C, layer_sel=1.
//  3 KEY_EN=1, req=4'b0010, rgb1=8'hFF, bg=8'h03 -> rgb_out=8'h03, layer_sel=4.
//  4 en_next=4'b1101 without frame_start -> layer1 still drawn; frame_start+pix_valid same cycle -> that pixel skips layer1.
//  5 pix_valid pattern 1,0,1 -> rgb_valid 1,0,1 delayed 2 clk; rgb_out held during gap.
//  6 COLLISION_EN: req 4'b1001 on 3 pixels, then frame_start -> collision_flags=3'b100 until next frame_start.

Source files
------------

// File: rtl/layer_priority_compositor_pkg.sv
// rtl/layer_priority_compositor_pkg.sv - shared constants and types for the layer compositor
package compositor_pkg;

  localparam int NUM_LAYERS_DEF = 4;
  localparam int RGB_W_DEF      = 8;

  // Layer roles on the VGA path; lower index wins
  localparam int LAYER_PLAYER = 0;
  localparam int LAYER_ENEMY  = 1;
  localparam int LAYER_SHOT   = 2;
  localparam int LAYER_HUD    = 3;

  localparam int SEL_W = $clog2(NUM_LAYERS_DEF + 1);

  typedef logic [RGB_W_DEF-1:0] rgb_t;

  localparam logic [SEL_W-1:0] BG_SEL = SEL_W'(NUM_LAYERS_DEF);

endpackage

// File: rtl/layer_priority_compositor_if.sv
// rtl/layer_priority_compositor_if.sv - pixel-in / pixel-out bundle of the layer compositor
interface layer_priority_compositor_if #(
  parameter int NUM_LAYERS = 4,
  parameter int RGB_W      = 8
);
  localparam int SEL_W = $clog2(NUM_LAYERS + 1);

  logic                        pix_valid;
  logic                        frame_start;
  logic [NUM_LAYERS-1:0]       layer_req;
  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb;
  logic [RGB_W-1:0]            bg_rgb;
  logic [NUM_LAYERS-1:0]       layer_en_next;
  logic [RGB_W-1:0]            rgb_out;
  logic                        rgb_valid;
  logic [SEL_W-1:0]            layer_sel;
`ifdef COMPOSITOR_COLLISION_EN
  logic [NUM_LAYERS-2:0]       collision_flags;

  modport master (
    output pix_valid, frame_start, layer_req, layer_rgb, bg_rgb, layer_en_next,
    input  rgb_out, rgb_valid, layer_sel, collision_flags
  );
  modport slave (
    input  pix_valid, frame_start, layer_req, layer_rgb, bg_rgb, layer_en_next,
    output rgb_out, rgb_valid, layer_sel, collision_flags
  );
`else
  modport master (
    output pix_valid, frame_start, layer_req, layer_rgb, bg_rgb, layer_en_next,
    input  rgb_out, rgb_valid, layer_sel
  );
  modport slave (
    input  pix_valid, frame_start, layer_req, layer_rgb, bg_rgb, layer_en_next,
    output rgb_out, rgb_valid, layer_sel
  );
`endif

endinterface

// File: rtl/layer_priority_compositor_prio_enc.sv
// rtl/layer_priority_compositor_prio_enc.sv - lowest-index-wins priority encoder
module layer_prio_enc #(
  parameter int N = 4,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         found
);

  // Scan high to low so the lowest set index is the last one written
  always_comb begin
    idx   = W'(N);
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) begin
        idx   = W'(k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/layer_priority_compositor.sv
// rtl/layer_priority_compositor.sv - 2-stage N-layer priority compositor; COMPOSITOR_COLLISION_EN adds layer-0 collision flags
module layer_priority_compositor
  import compositor_pkg::*;
#(
  parameter int               NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int               RGB_W      = RGB_W_DEF,
  parameter bit               KEY_EN     = 1'b1,
  parameter logic [RGB_W-1:0] KEY_RGB    = {RGB_W{1'b1}}
) (
  input  logic                          clk,
  input  logic                          reset,
  layer_priority_compositor_if.slave    bus
);

  localparam int SW = $clog2(NUM_LAYERS + 1);
  localparam logic [SW-1:0] BG_IDX = SW'(NUM_LAYERS);

  logic [NUM_LAYERS-1:0] en_shadow;
  logic [NUM_LAYERS-1:0] mask_now;
  logic [NUM_LAYERS-1:0] eff_req;
  logic [SW-1:0]         win_idx;
  logic                  win_found;
  logic [RGB_W-1:0]      win_rgb;

  logic                  s1_valid;
  logic [SW-1:0]         s1_sel;
  logic [RGB_W-1:0]      s1_rgb;

  logic [RGB_W-1:0]      rgb_q;
  logic                  valid_q;
  logic [SW-1:0]         sel_q;

  // A frame_start pixel already sees the incoming mask
  always_comb begin
    mask_now = bus.frame_start ? bus.layer_en_next : en_shadow;
  end

  always_comb begin
    eff_req = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      eff_req[k] = bus.layer_req[k] & mask_now[k] &
                   ~(KEY_EN && (bus.layer_rgb[k*RGB_W +: RGB_W] == KEY_RGB));
    end
  end

  layer_prio_enc #(.N(NUM_LAYERS), .W(SW)) u_enc (
    .req   (eff_req),
    .idx   (win_idx),
    .found (win_found)
  );

  always_comb begin
    win_rgb = bus.bg_rgb;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (win_found && (int'(win_idx) == k)) begin
        win_rgb = bus.layer_rgb[k*RGB_W +: RGB_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_shadow <= '1;
    end else if (bus.frame_start) begin
      en_shadow <= bus.layer_en_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sel   <= BG_IDX;
      s1_rgb   <= '0;
    end else begin
      s1_valid <= bus.pix_valid;
      if (bus.pix_valid) begin
        s1_sel <= win_idx;
        s1_rgb <= win_rgb;
      end
    end
  end

  // Output data holds across gaps so the VGA register keeps the last pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      sel_q   <= BG_IDX;
      rgb_q   <= '0;
    end else begin
      valid_q <= s1_valid;
      if (s1_valid) begin
        sel_q <= s1_sel;
        rgb_q <= s1_rgb;
      end
    end
  end

  assign bus.rgb_out   = rgb_q;
  assign bus.rgb_valid = valid_q;
  assign bus.layer_sel = sel_q;

`ifdef COMPOSITOR_COLLISION_EN
  logic [NUM_LAYERS-2:0] hits;
  logic [NUM_LAYERS-2:0] sticky;
  logic [NUM_LAYERS-2:0] flags_q;

  always_comb begin
    hits = '0;
    for (int k = 1; k < NUM_LAYERS; k++) begin
      hits[k-1] = bus.pix_valid & eff_req[0] & eff_req[k];
    end
  end

  // Flags publish the previous frame's hits and stay frozen for a whole frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky  <= '0;
      flags_q <= '0;
    end else if (bus.frame_start) begin
      flags_q <= sticky;
      sticky  <= hits;
    end else begin
      sticky  <= sticky | hits;
    end
  end

  assign bus.collision_flags = flags_q;
`endif

endmodule

// File: tb/tb_layer_priority_compositor.sv
// tb/tb_layer_priority_compositor.sv - directed self-checking bench for layer_priority_compositor
`timescale 1ns/1ps
module tb_layer_priority_compositor;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  layer_priority_compositor_if #(.NUM_LAYERS(4), .RGB_W(8)) bus ();

  layer_priority_compositor #(
    .NUM_LAYERS(4), .RGB_W(8), .KEY_EN(1'b1), .KEY_RGB(8'hFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input logic v, input logic fs, input logic [3:0] req,
                        input logic [7:0] r0, input logic [7:0] r1,
                        input logic [7:0] r2, input logic [7:0] r3,
                        input logic [7:0] bg, input logic [3:0] en);
    bus.pix_valid     = v;
    bus.frame_start   = fs;
    bus.layer_req     = req;
    bus.layer_rgb     = {r3, r2, r1, r0};
    bus.bg_rgb        = bg;
    bus.layer_en_next = en;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_px(1'b0, 1'b0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1111);
    cycle();
    cycle();
    checks++; if (bus.rgb_out !== 8'h00) begin errors++; $display("FAIL reset_rgb: got %h expected 00", bus.rgb_out); end
    checks++; if (bus.rgb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.rgb_valid); end
    checks++; if (bus.layer_sel !== 3'd4) begin errors++; $display("FAIL reset_sel: got %0d expected 4", bus.layer_sel); end
`ifdef COMPOSITOR_COLLISION_EN
    checks++; if (bus.collision_flags !== 3'b000) begin errors++; $display("FAIL reset_coll: got %b expected 000", bus.collision_flags); end
`endif
    reset = 1'b0;
    // Stream starts with a mask hiding layer 0
    set_px(1'b1, 1'b1, 4'b0001, 8'h12, 8'h00, 8'h00, 8'h00, 8'h03, 4'b1110);
    cycle();
    set_px(1'b1, 1'b0, 4'b0001, 8'h12, 8'h00, 8'h00, 8'h00, 8'h03, 4'b1111);
    cycle();
    checks++; if (bus.rgb_out !== 8'h03 || bus.layer_sel !== 3'd4 || bus.rgb_valid !== 1'b1) begin
      errors++; $display("FAIL prereset_masked: got rgb=%h sel=%0d v=%b expected rgb=03 sel=4 v=1", bus.rgb_out, bus.layer_sel, bus.rgb_valid); end
    #3 reset = 1'b1;
    #1;
    checks++; if (bus.rgb_out !== 8'h00 || bus.rgb_valid !== 1'b0 || bus.layer_sel !== 3'd4) begin
      errors++; $display("FAIL midline_reset: got rgb=%h v=%b sel=%0d expected rgb=00 v=0 sel=4", bus.rgb_out, bus.rgb_valid, bus.layer_sel); end
    cycle();
    reset = 1'b0;
    cycle();
    checks++; if (bus.rgb_valid !== 1'b0) begin errors++; $display("FAIL release_lat1: got v=%b expected 0", bus.rgb_valid); end
    cycle();
    checks++; if (bus.rgb_valid !== 1'b1 || bus.rgb_out !== 8'h12 || bus.layer_sel !== 3'd0) begin
      errors++; $display("FAIL release_lat2: got v=%b rgb=%h sel=%0d expected v=1 rgb=12 sel=0", bus.rgb_valid, bus.rgb_out, bus.layer_sel); end
    bus.pix_valid = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic test_priority();
    set_px(1'b1, 1'b0, 4'b0110, 8'h00, 8'h1C, 8'hE0, 8'h00, 8'h03, 4'b1111);
    cycle();
    bus.pix_valid = 1'b0;
    cycle();
    checks++; if (bus.rgb_out !== 8'h1C || bus.layer_sel !== 3'd1 || bus.rgb_valid !== 1'b1) begin
      errors++; $display("FAIL priority: got rgb=%h sel=%0d v=%b expected rgb=1c sel=1 v=1", bus.rgb_out, bus.layer_sel, bus.rgb_valid); end
    cycle();
    checks++; if (bus.rgb_valid !== 1'b0 || bus.rgb_out !== 8'h1C) begin
      errors++; $display("FAIL priority_idle: got v=%b rgb=%h expected v=0 rgb=1c", bus.rgb_valid, bus.rgb_out); end
  endtask

  task automatic test_key();
    set_px(1'b1, 1'b0, 4'b0010, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h03, 4'b1111);
    cycle();
    bus.pix_valid = 1'b0;
    cycle();
    checks++; if (bus.rgb_out !== 8'h03 || bus.layer_sel !== 3'd4) begin
      errors++; $display("FAIL colour_key: got rgb=%h sel=%0d expected rgb=03 sel=4", bus.rgb_out, bus.layer_sel); end
  endtask

  task automatic test_mask();
    set_px(1'b1, 1'b0, 4'b0010, 8'h00, 8'h55, 8'h00, 8'h00, 8'h03, 4'b1101);
    cycle();
    set_px(1'b1, 1'b1, 4'b0110, 8'h00, 8'h1C, 8'hE0, 8'h00, 8'h03, 4'b1101);
    cycle();
    checks++; if (bus.rgb_out !== 8'h55 || bus.layer_sel !== 3'd1) begin
      errors++; $display("FAIL mask_pending: got rgb=%h sel=%0d expected rgb=55 sel=1", bus.rgb_out, bus.layer_sel); end
    set_px(1'b1, 1'b0, 4'b0110, 8'h00, 8'h1C, 8'hE0, 8'h00, 8'h03, 4'b1111);
    cycle();
    checks++; if (bus.rgb_out !== 8'hE0 || bus.layer_sel !== 3'd2) begin
      errors++; $display("FAIL mask_same_cycle: got rgb=%h sel=%0d expected rgb=e0 sel=2", bus.rgb_out, bus.layer_sel); end
    set_px(1'b1, 1'b1, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 4'b0000);
    cycle();
    checks++; if (bus.rgb_out !== 8'hE0 || bus.layer_sel !== 3'd2) begin
      errors++; $display("FAIL mask_shadow_hold: got rgb=%h sel=%0d expected rgb=e0 sel=2", bus.rgb_out, bus.layer_sel); end
    set_px(1'b0, 1'b1, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'b1111);
    cycle();
    checks++; if (bus.rgb_out !== 8'h5A || bus.layer_sel !== 3'd4) begin
      errors++; $display("FAIL mask_all_zero: got rgb=%h sel=%0d expected rgb=5a sel=4", bus.rgb_out, bus.layer_sel); end
    bus.frame_start = 1'b0;
    cycle();
  endtask

  task automatic test_gap();
    set_px(1'b1, 1'b0, 4'b0100, 8'h00, 8'h00, 8'hE0, 8'h00, 8'h03, 4'b1111);
    cycle();
    bus.pix_valid = 1'b0;
    cycle();
    checks++; if (bus.rgb_valid !== 1'b1 || bus.rgb_out !== 8'hE0 || bus.layer_sel !== 3'd2) begin
      errors++; $display("FAIL gap_first: got v=%b rgb=%h sel=%0d expected v=1 rgb=e0 sel=2", bus.rgb_valid, bus.rgb_out, bus.layer_sel); end
    set_px(1'b1, 1'b0, 4'b1000, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h03, 4'b1111);
    cycle();
    checks++; if (bus.rgb_valid !== 1'b0 || bus.rgb_out !== 8'hE0 || bus.layer_sel !== 3'd2) begin
      errors++; $display("FAIL gap_hold: got v=%b rgb=%h sel=%0d expected v=0 rgb=e0 sel=2", bus.rgb_valid, bus.rgb_out, bus.layer_sel); end
    bus.pix_valid = 1'b0;
    cycle();
    checks++; if (bus.rgb_valid !== 1'b1 || bus.rgb_out !== 8'h3C || bus.layer_sel !== 3'd3) begin
      errors++; $display("FAIL gap_second: got v=%b rgb=%h sel=%0d expected v=1 rgb=3c sel=3", bus.rgb_valid, bus.rgb_out, bus.layer_sel); end
    cycle();
  endtask

  task automatic test_back_to_back();
    set_px(1'b1, 1'b0, 4'b1111, 8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 4'b1111);
    cycle();
    set_px(1'b1, 1'b0, 4'b1111, 8'hFF, 8'h22, 8'h33, 8'h44, 8'h5A, 4'b1111);
    cycle();
    checks++; if (bus.rgb_out !== 8'h11 || bus.layer_sel !== 3'd0 || bus.rgb_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_p0: got rgb=%h sel=%0d v=%b expected rgb=11 sel=0 v=1", bus.rgb_out, bus.layer_sel, bus.rgb_valid); end
    set_px(1'b1, 1'b0, 4'b0000, 8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 4'b1111);
    cycle();
    checks++; if (bus.rgb_out !== 8'h22 || bus.layer_sel !== 3'd1 || bus.rgb_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_p1: got rgb=%h sel=%0d v=%b expected rgb=22 sel=1 v=1", bus.rgb_out, bus.layer_sel, bus.rgb_valid); end
    bus.pix_valid = 1'b0;
    cycle();
    checks++; if (bus.rgb_out !== 8'h5A || bus.layer_sel !== 3'd4 || bus.rgb_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_p2: got rgb=%h sel=%0d v=%b expected rgb=5a sel=4 v=1", bus.rgb_out, bus.layer_sel, bus.rgb_valid); end
    cycle();
  endtask

`ifdef COMPOSITOR_COLLISION_EN
  task automatic test_collision();
    set_px(1'b1, 1'b1, 4'b0000, 8'h11, 8'h22, 8'h33, 8'h44, 8'h03, 4'b1111);
    cycle();
    for (int i = 0; i < 3; i++) begin
      set_px(1'b1, 1'b0, 4'b1001, 8'h11, 8'h22, 8'h33, 8'h44, 8'h03, 4'b1111);
      cycle();
    end
    set_px(1'b1, 1'b1, 4'b0000, 8'h11, 8'h22, 8'h33, 8'h44, 8'h03, 4'b1111);
    cycle();
    checks++; if (bus.collision_flags !== 3'b100) begin errors++; $display("FAIL coll_publish: got %b expected 100", bus.collision_flags); end
    set_px(1'b1, 1'b0, 4'b0110, 8'h11, 8'h22, 8'h33, 8'h44, 8'h03, 4'b1111);
    cycle();
    cycle();
    checks++; if (bus.collision_flags !== 3'b100) begin errors++; $display("FAIL coll_stable: got %b expected 100", bus.collision_flags); end
    set_px(1'b0, 1'b1, 4'b0000, 8'h11, 8'h22, 8'h33, 8'h44, 8'h03, 4'b1111);
    cycle();
    checks++; if (bus.collision_flags !== 3'b000) begin errors++; $display("FAIL coll_next_frame: got %b expected 000", bus.collision_flags); end
    bus.frame_start = 1'b0;
    cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_priority();
    test_key();
    test_mask();
    test_gap();
    test_back_to_back();
`ifdef COMPOSITOR_COLLISION_EN
    test_collision();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
